// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter: flattened requests in, grant and ALU flags out.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*33-1:0] req_a;
   logic [NUM_REQ*33-1:0] req_b;
   logic [NUM_REQ*5-1:0]  req_op;
   logic [NUM_REQ-1:0]    grant;
   logic [31:0]           result;
   logic                  lt;
   logic                  ltu;
   logic                  eq;

   modport master (
      output req_valid, req_a, req_b, req_op,
      input  grant, result, lt, ltu, eq
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op,
      output grant, result, lt, ltu, eq
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with hold timeout and flush.
//
//   state | meaning
//   IDLE  | no owner, grant == 0, ALU driven with IDLE_OP
//   OWNED | one requester owns the ALU, grant one-hot, hold_cnt counts held cycles
module alu_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 16,
   parameter int IDLE_OP = 8,
   localparam int IW = $clog2(NUM_REQ),
   localparam int HW = $clog2(TIMEOUT) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   alu_arbiter_if.slave      bus,
   output logic [32:0]       alu_in_a,
   output logic [32:0]       alu_in_b,
   output logic [4:0]        alu_op,
   input  logic [31:0]       alu_result,
   input  logic              alu_lt,
   input  logic              alu_ltu,
   input  logic              alu_eq,
   output logic              busy,
   output logic [IW-1:0]     owner_idx,
   output logic              timeout_err
);

   typedef enum logic {IDLE, OWNED} state_t;

   localparam logic [HW-1:0] HOLD_MAX = HW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   state_t               state, state_n;
   logic [NUM_REQ-1:0]   grant, grant_n;
   logic [IW-1:0]        owner, owner_n, owner_inc;
   logic [IW-1:0]        rr_ptr, rr_n;
   logic [HW-1:0]        hold_cnt, hold_n;
   logic                 terr_n;
   logic [IW-1:0]        scan_start, scan_idx, sel;
   logic                 found, excl_owner, owner_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         owner       <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         owner       <= owner_n;
         rr_ptr      <= rr_n;
         hold_cnt    <= hold_n;
         timeout_err <= terr_n;
      end
   end

   assign owner_inc   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
   assign owner_valid = bus.req_valid[owner];

   // On release/timeout the scan starts just past the owner, which is the new rr_ptr.
   always_comb begin
      excl_owner = (state == OWNED);
      scan_start = excl_owner ? owner_inc : rr_ptr;
      found      = 1'b0;
      sel        = '0;
      scan_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = IW'((int'(scan_start) + k) % NUM_REQ);
         if (!found && bus.req_valid[scan_idx] && !(excl_owner && scan_idx == owner)) begin
            found = 1'b1;
            sel   = scan_idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      owner_n = owner;
      rr_n    = rr_ptr;
      hold_n  = hold_cnt;
      terr_n  = 1'b0;
      if (flush) begin
         state_n = IDLE;
         grant_n = '0;
         owner_n = '0;
         hold_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state_n      = OWNED;
                  grant_n      = '0;
                  grant_n[sel] = 1'b1;
                  owner_n      = sel;
                  hold_n       = '0;
               end
            end
            OWNED: begin
               if (owner_valid && hold_cnt != HOLD_MAX) begin
                  hold_n = hold_cnt + 1'b1;
               end else begin
                  terr_n = owner_valid;
                  rr_n   = owner_inc;
                  hold_n = '0;
                  if (found) begin
                     grant_n      = '0;
                     grant_n[sel] = 1'b1;
                     owner_n      = sel;
                  end else begin
                     state_n = IDLE;
                     grant_n = '0;
                     owner_n = '0;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               grant_n = '0;
               owner_n = '0;
               hold_n  = '0;
            end
         endcase
      end
   end

   // Operands pass only while the owner is still asserting its request.
   always_comb begin
      alu_in_a = '0;
      alu_in_b = '0;
      alu_op   = 5'(IDLE_OP);
      if (state == OWNED && grant[owner] && owner_valid) begin
         alu_in_a = bus.req_a[33*owner +: 33];
         alu_in_b = bus.req_b[33*owner +: 33];
         alu_op   = bus.req_op[5*owner +: 5];
      end
   end

   assign bus.grant  = grant;
   assign bus.result = alu_result;
   assign bus.lt     = alu_lt;
   assign bus.ltu    = alu_ltu;
   assign bus.eq     = alu_eq;
   assign busy       = |grant;
   assign owner_idx  = owner;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: NUM_REQ=3, TIMEOUT=4, hand-computed grants and ALU muxing.
module tb_alu_arbiter;
   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [32:0] alu_in_a, alu_in_b;
   logic [4:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_lt, alu_ltu, alu_eq;
   logic        busy;
   logic [1:0]  owner_idx;
   logic        timeout_err;
   int          checks = 0;
   int          errors = 0;

   localparam logic [32:0] A0 = 33'h1_2345_6789, A1 = 33'h0_AAAA_0001, A2 = 33'h1_5555_0002;
   localparam logic [32:0] B0 = 33'h0_0000_0011, B1 = 33'h1_FFFF_0022, B2 = 33'h0_1234_0033;
   localparam logic [4:0]  OP0 = 5'd3, OP1 = 5'd12, OP2 = 5'd21;

   alu_arbiter_if #(.NUM_REQ(N)) bus ();

   alu_arbiter #(.NUM_REQ(N), .TIMEOUT(4), .IDLE_OP(8)) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .alu_eq(alu_eq),
      .busy(busy), .owner_idx(owner_idx), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.req_valid = '0;
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.req_valid = 3'b111;
      step();
      step();
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", bus.grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (owner_idx !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner_idx); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
      checks++; if (alu_in_a !== 33'h0 || alu_in_b !== 33'h0) begin errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", alu_in_a, alu_in_b); end
      checks++; if (alu_op !== 5'd8) begin errors++; $display("FAIL reset_op: got %0d expected 8", alu_op); end
   endtask

   task automatic test_grant_and_round_robin();
      do_reset();
      bus.req_valid = 3'b011;
      step();
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL first_grant: got %b expected 001", bus.grant); end
      checks++; if (alu_op !== OP0 || alu_in_a !== A0 || alu_in_b !== B0) begin errors++; $display("FAIL first_mux: got op %0d a %h b %h expected op %0d a %h b %h", alu_op, alu_in_a, alu_in_b, OP0, A0, B0); end
      checks++; if (owner_idx !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL first_owner: got idx %0d busy %b expected 0 1", owner_idx, busy); end
      bus.req_valid = 3'b111;
      step();
      step();
      bus.req_valid = 3'b110;
      alu_result = 32'hDEAD_BEEF;
      #1;
      checks++; if (alu_in_a !== 33'h0 || alu_in_b !== 33'h0 || alu_op !== 5'd8) begin errors++; $display("FAIL release_mux: got a %h b %h op %0d expected 0 0 8", alu_in_a, alu_in_b, alu_op); end
      checks++; if (bus.result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL release_result: got %h expected deadbeef", bus.result); end
      step();
      checks++; if (bus.grant !== 3'b010 || owner_idx !== 2'd1) begin errors++; $display("FAIL rr_to_1: got %b idx %0d expected 010 idx 1", bus.grant, owner_idx); end
      checks++; if (alu_op !== OP1 || alu_in_b !== B1) begin errors++; $display("FAIL mux_1: got op %0d b %h expected op %0d b %h", alu_op, alu_in_b, OP1, B1); end
      step();
      step();
      bus.req_valid = 3'b100;
      step();
      checks++; if (bus.grant !== 3'b100 || owner_idx !== 2'd2) begin errors++; $display("FAIL rr_to_2: got %b idx %0d expected 100 idx 2", bus.grant, owner_idx); end
      checks++; if (alu_in_a !== A2 || alu_op !== OP2) begin errors++; $display("FAIL mux_2: got a %h op %0d expected a %h op %0d", alu_in_a, alu_op, A2, OP2); end
   endtask

   task automatic test_reset_mid_ownership();
      bus.req_valid = 3'b101;
      reset = 1'b0;
      step();
      checks++; if (bus.grant !== 3'b000 || owner_idx !== 2'd0) begin errors++; $display("FAIL mid_reset: got %b idx %0d expected 000 idx 0", bus.grant, owner_idx); end
      reset = 1'b1;
      step();
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL rr_ptr_reset: got %b expected 001", bus.grant); end
      do_reset();
      bus.req_valid = 3'b100;
      step();
      checks++; if (bus.grant !== 3'b100 || owner_idx !== 2'd2) begin errors++; $display("FAIL req2_alone: got %b idx %0d expected 100 idx 2", bus.grant, owner_idx); end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.req_valid = 3'b001;
      for (int c = 2; c <= 5; c++) begin
         step();
         checks++; if (bus.grant !== 3'b001 || timeout_err !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d: got %b terr %b expected 001 terr 0", c, bus.grant, timeout_err); end
      end
      step();
      checks++; if (bus.grant !== 3'b000 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout: got %b terr %b expected 000 terr 1", bus.grant, timeout_err); end
      step();
      checks++; if (bus.grant !== 3'b001 || timeout_err !== 1'b0) begin errors++; $display("FAIL regrant: got %b terr %b expected 001 terr 0", bus.grant, timeout_err); end
   endtask

   task automatic test_timeout_handover();
      do_reset();
      bus.req_valid = 3'b011;
      for (int c = 0; c < 4; c++) step();
      step();
      checks++; if (bus.grant !== 3'b010 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_handover: got %b terr %b expected 010 terr 1", bus.grant, timeout_err); end
   endtask

   task automatic test_flush_timeout();
      do_reset();
      bus.req_valid = 3'b011;
      for (int c = 0; c < 4; c++) step();
      flush = 1'b1;
      step();
      checks++; if (bus.grant !== 3'b000 || timeout_err !== 1'b0) begin errors++; $display("FAIL flush_timeout: got %b terr %b expected 000 terr 0", bus.grant, timeout_err); end
      step();
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL flush_idle: got %b expected 000", bus.grant); end
      flush = 1'b0;
      step();
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL flush_rr_kept: got %b expected 001", bus.grant); end
   endtask

   task automatic test_broadcast();
      alu_result = 32'h0F0F_1234;
      alu_lt = 1'b1; alu_ltu = 1'b0; alu_eq = 1'b1;
      #1;
      checks++; if (bus.result !== 32'h0F0F_1234 || {bus.lt, bus.ltu, bus.eq} !== 3'b101) begin errors++; $display("FAIL broadcast: got %h %b expected 0f0f1234 101", bus.result, {bus.lt, bus.ltu, bus.eq}); end
      alu_lt = 1'b0; alu_ltu = 1'b1; alu_eq = 1'b0;
      #1;
      checks++; if ({bus.lt, bus.ltu, bus.eq} !== 3'b010) begin errors++; $display("FAIL broadcast_flags: got %b expected 010", {bus.lt, bus.ltu, bus.eq}); end
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      bus.req_valid = '0;
      bus.req_a = {A2, A1, A0};
      bus.req_b = {B2, B1, B0};
      bus.req_op = {OP2, OP1, OP0};
      alu_result = '0;
      alu_lt = 1'b0; alu_ltu = 1'b0; alu_eq = 1'b0;
      test_reset();
      test_grant_and_round_robin();
      test_reset_mid_ownership();
      test_timeout();
      test_timeout_handover();
      test_flush_timeout();
      test_broadcast();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesters sharing one alu instance (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16: max consecutive cycles one owner holds the ALU with req_valid high.
REQ-003 SHALL have parameter IDLE_OP, default 8: alu_op driven when no owner drives the ALU.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled on clk rising edge.
REQ-006 flush  input  1  pipeline flush; revokes ownership.
REQ-007 req_valid  input  NUM_REQ  per-requester ALU request/hold.
REQ-008 req_a, req_b  input  NUM_REQ*33  flattened operands; requester i at bits [33*i+32:33*i].
REQ-009 req_op  input  NUM_REQ*5  flattened ALU op; requester i at [5*i+4:5*i].
REQ-010 grant  output  NUM_REQ  registered one-hot (or zero) ownership.
REQ-011 alu_in_a, alu_in_b  output  33  operands to alu; alu_op  output  5.
REQ-012 alu_result  input  32; alu_lt, alu_ltu, alu_eq  input  1 each: from alu.
REQ-013 result  output  32; lt, ltu, eq  output  1 each: alu outputs broadcast unmodified to all requesters.
REQ-014 busy  output  1  equals |grant.
REQ-015 owner_idx  output  clog2(NUM_REQ)  index of granted requester; 0 when idle.
REQ-016 timeout_err  output  1  one-cycle pulse when ownership revoked by timeout.

Function
REQ-017 States: IDLE (grant==0) and OWNED (grant one-hot); state held in registers only.
REQ-018 ALU mux SHALL be combinational: if grant[i] and req_valid[i], drive req_a/req_b/req_op of i; else alu_in_a=0, alu_in_b=0, alu_op=IDLE_OP.
REQ-019 Selection: first requester with req_valid high, scanning circularly from rr_ptr upward; rr_ptr resets to 0.
REQ-020 IDLE, no flush, any req_valid in cycle N: grant for selected requester SHALL be high in cycle N+1; hold_cnt=0; otherwise stay IDLE.
REQ-021 OWNED, owner req_valid high, hold_cnt<TIMEOUT-1, no flush: grant unchanged, hold_cnt increments.
REQ-022 Release: OWNED and owner req_valid low in cycle R: selection among other requesters (owner excluded) in R; new grant (or zero) in R+1; rr_ptr=owner+1 mod NUM_REQ.
REQ-023 Timeout: OWNED, owner req_valid high, hold_cnt==TIMEOUT-1 in cycle T: timeout_err=1 in T+1, owner excluded from selection in T, rr_ptr=owner+1 mod NUM_REQ, next grant as REQ-022.
REQ-024 Revoked owner still requesting SHALL be re-eligible from T+1 under normal round-robin.
REQ-025 Flush in cycle F: grant=0 and state IDLE in F+1; no selection in F; rr_ptr and timeout_err unaffected by any timeout coincident with F (flush wins, timeout_err=0).
REQ-026 hold_cnt width clog2(TIMEOUT)+1; cleared on every new grant, flush, reset.
REQ-027 Never more than one grant bit high; grant never asserted for requester with req_valid low at selection.
REQ-028 result/lt/ltu/eq SHALL have zero latency from alu inputs; requesters qualify with own grant.

Reset
REQ-029 reset low at a clk edge: grant=0, state IDLE, rr_ptr=0, hold_cnt=0, timeout_err=0 next cycle, overriding flush, release and timeout, including mid-ownership.
REQ-030 During/after reset with no grant: busy=0, owner_idx=0, alu_in_a=0, alu_in_b=0, alu_op=IDLE_OP.

Verification
REQ-031 Reset then req_valid=3'b011 at cycle 1 -> grant=3'b001 cycle 2, alu_op=req_op[0], owner_idx=0, busy=1.
REQ-032 Owner 0 drops req_valid cycle 5 with req1,req2 pending -> grant=3'b010 cycle 6; req1 drops cycle 8 -> grant=3'b100 cycle 9 (round-robin).
REQ-033 TIMEOUT=4, req0 held high alone from cycle 1 -> grant 001 cycles 2-5, grant 000 and timeout_err=1 cycle 6, grant 001 again cycle 7.
REQ-034 Flush in same cycle as timeout condition -> grant=0 next cycle, timeout_err stays 0, rr_ptr unchanged.
REQ-035 Granted owner with req_valid low in release cycle -> alu_in_a=0, alu_in_b=0, alu_op=8 that cycle; alu_result=32'hDEADBEEF forced -> result=32'hDEADBEEF same cycle.
REQ-036 reset low mid-ownership (grant=3'b100) -> next cycle grant=0, owner_idx=0; next request from req2 alone granted with rr_ptr=0 scan.
